// File: rtl/pc_update_unit_pkg.sv
// ----------------------------------------------------------------------------
// pc_update_unit_pkg
// Shared types and constants for the program-counter update unit.
//   state_t  : FSM state encoding (S_RUN = 1'b0, S_STALL = 1'b1)
//   PC_STEP  : sequential instruction step (one 32-bit word)
// ----------------------------------------------------------------------------
package pc_update_unit_pkg;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_STALL = 1'b1
    } state_t;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/pc_update_unit_incrementer.sv
// ----------------------------------------------------------------------------
// pc_update_unit_incrementer
// Sequential-address adder: o_pc_plus4 = i_pc + 4, unsigned modulo 2^32.
// 32'hFFFF_FFFC wraps to 0 with no carry flag.
// Ports:
//   i_pc        in  32  current program counter
//   o_pc_plus4  out 32  next sequential address
// ----------------------------------------------------------------------------
module pc_update_unit_incrementer
    import pc_update_unit_pkg::*;
(
    input  logic [31:0] i_pc,
    output logic [31:0] o_pc_plus4
);

    assign o_pc_plus4 = i_pc + PC_STEP;

endmodule

// File: rtl/pc_update_unit.sv
// ----------------------------------------------------------------------------
// pc_update_unit
// Program-counter register and next-PC selector for the single-cycle CPU.
// Holds the PC while memory stalls and latches the first taken redirect seen
// during a stall so it is applied when the stall releases.
//
// Optional feature macro: PC_UNIT_BNE_EN (adds i_bne, branch-if-not-equal).
//
// Ports:
//   i_clk               in  1   system clock, posedge active
//   i_reset             in  1   synchronous active-high reset
//   i_busywait          in  1   memory stall, 1 = hold PC
//   i_jump              in  1   unconditional jump
//   i_branch            in  1   branch-if-equal
//   i_zero              in  1   ALU zero flag
//   i_bne               in  1   branch-if-not-equal (PC_UNIT_BNE_EN only)
//   i_target_addr       in  32  branch/jump target from target adder
//   o_pc                out 32  current instruction address
//   o_pc_plus4          out 32  PC + 4, feeds target adder
//   o_stalled           out 1   1 while in S_STALL
//   o_redirect_pending  out 1   1 while a latched redirect awaits release
//
// state   | meaning
// S_RUN   | normal fetch, PC advances every cycle
// S_STALL | memory busy, PC held, first taken redirect captured
// ----------------------------------------------------------------------------
module pc_update_unit
    import pc_update_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_busywait,
    input  logic        i_jump,
    input  logic        i_branch,
    input  logic        i_zero,
`ifdef PC_UNIT_BNE_EN
    input  logic        i_bne,
`endif
    input  logic [31:0] i_target_addr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic        o_stalled,
    output logic        o_redirect_pending
);

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_redir_vld;
    logic [31:0] r_redir_addr;
    logic [31:0] w_pc_plus4;
    logic        w_taken;

    pc_update_unit_incrementer u_inc (
        .i_pc       (r_pc),
        .o_pc_plus4 (w_pc_plus4)
    );

`ifdef PC_UNIT_BNE_EN
    assign w_taken = i_jump | (i_branch & i_zero) | (i_bne & ~i_zero);
`else
    assign w_taken = i_jump | (i_branch & i_zero);
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc         <= RESET_PC;
            r_state      <= S_RUN;
            r_redir_vld  <= 1'b0;
            r_redir_addr <= 32'd0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (!i_busywait) begin
                        r_pc <= w_taken ? i_target_addr : w_pc_plus4;
                    end else begin
                        r_state <= S_STALL;
                        if (w_taken) begin
                            r_redir_vld  <= 1'b1;
                            r_redir_addr <= i_target_addr;
                        end
                    end
                end
                S_STALL: begin
                    if (i_busywait) begin
                        // first capture wins; later decisions in the stall are dropped
                        if (!r_redir_vld && w_taken) begin
                            r_redir_vld  <= 1'b1;
                            r_redir_addr <= i_target_addr;
                        end
                    end else begin
                        if (r_redir_vld)
                            r_pc <= r_redir_addr;
                        else
                            r_pc <= w_taken ? i_target_addr : w_pc_plus4;
                        r_redir_vld <= 1'b0;
                        r_state     <= S_RUN;
                    end
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

    assign o_pc               = r_pc;
    assign o_pc_plus4         = w_pc_plus4;
    assign o_stalled          = (r_state == S_STALL);
    assign o_redirect_pending = r_redir_vld;

endmodule
